imem_loader: RTL and testbench

Byte-stream program loader that fills the instruction memory of the single-cycle RISC-V core before execution. It parses a framed byte stream, assembles little-endian 32-bit words, and issues word writes on the instruction memory's write port. It holds the core in reset while loading and releases it only after a valid frame checksum. It is the writer on the memory interface the core fetches from.

---
 rtl/imem_loader.sv | 156 +++++++++++++++
 tb/tb_imem_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory: parses A5/N/data/CHK frames,
// writes little-endian words, and holds the core in reset until a frame checks out.
module imem_loader #(
    parameter int WIDTH = 32,
    parameter int ADD   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             cpu_rst,
    output logic             done,
    output logic             error,
    output logic [ADD:0]     load_count
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LEN0 = 3'd1;
    localparam logic [2:0] LEN1 = 3'd2;
    localparam logic [2:0] DATA = 3'd3;
    localparam logic [2:0] CHK  = 3'd4;
    localparam logic [2:0] DONE = 3'd5;
    localparam logic [2:0] ERR  = 3'd6;

    localparam logic [7:0]  HEADER   = 8'hA5;
    localparam logic [16:0] CAPACITY = 17'(2 ** ADD);

    logic [2:0]       state_reg;
    logic [7:0]       len_lo_reg;
    logic [15:0]      len_reg;
    logic [1:0]       lane_reg;
    logic [7:0]       chk_reg;
    logic [ADD:0]     count_reg;
    logic             mem_we_reg;
    logic [WIDTH-1:0] mem_addr_reg;
    logic [WIDTH-1:0] mem_wdata_reg;
    logic             cpu_rst_reg;
    logic             done_reg;
    logic             error_reg;

    logic             accept;
    logic [15:0]      len_next;
    logic [ADD:0]     count_next;
    logic             word_last;

    // The write cycle doubles as the stall cycle, so no byte is lost while mem_we is high.
    assign rx_ready   = ~mem_we_reg;
    assign accept     = rx_valid & rx_ready;
    assign len_next   = {rx_data, len_lo_reg};
    assign count_next = count_reg + {{ADD{1'b0}}, 1'b1};
    assign word_last  = (17'(count_next) == {1'b0, len_reg});

    // Lanes 0..2 are buffered; lane 3 comes straight from rx_data when the word is issued.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] byte_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    byte_reg <= 8'h00;
                end else if (accept && state_reg == DATA && lane_reg == 2'(gi)) begin
                    byte_reg <= rx_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            len_lo_reg    <= 8'h00;
            len_reg       <= 16'h0000;
            lane_reg      <= 2'd0;
            chk_reg       <= 8'h00;
            count_reg     <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            cpu_rst_reg   <= 1'b1;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            mem_we_reg <= 1'b0;
            if (accept) begin
                case (state_reg)
                    IDLE: begin
                        if (rx_data == HEADER) state_reg <= LEN0;
                    end
                    LEN0: begin
                        len_lo_reg <= rx_data;
                        state_reg  <= LEN1;
                    end
                    LEN1: begin
                        // Counters restart for every frame so an empty frame reports zero words.
                        len_reg   <= len_next;
                        lane_reg  <= 2'd0;
                        chk_reg   <= 8'h00;
                        count_reg <= '0;
                        if ({1'b0, len_next} > CAPACITY) begin
                            state_reg <= ERR;
                            error_reg <= 1'b1;
                        end else if (len_next == 16'h0000) begin
                            state_reg <= CHK;
                        end else begin
                            state_reg <= DATA;
                        end
                    end
                    DATA: begin
                        chk_reg  <= chk_reg ^ rx_data;
                        lane_reg <= lane_reg + 2'd1;
                        if (lane_reg == 2'd3) begin
                            mem_we_reg    <= 1'b1;
                            mem_addr_reg  <= {{(WIDTH-ADD-2){1'b0}}, count_reg[ADD-1:0], 2'b00};
                            mem_wdata_reg <= {rx_data, g_lane[2].byte_reg,
                                              g_lane[1].byte_reg, g_lane[0].byte_reg};
                            count_reg     <= count_next;
                            if (word_last) state_reg <= CHK;
                        end
                    end
                    CHK: begin
                        if (rx_data == chk_reg) begin
                            state_reg   <= DONE;
                            done_reg    <= 1'b1;
                            cpu_rst_reg <= 1'b0;
                        end else begin
                            state_reg <= ERR;
                            error_reg <= 1'b1;
                        end
                    end
                    DONE, ERR: begin
                        if (rx_data == HEADER) begin
                            state_reg   <= LEN0;
                            done_reg    <= 1'b0;
                            error_reg   <= 1'b0;
                            cpu_rst_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign cpu_rst    = cpu_rst_reg;
    assign done       = done_reg;
    assign error      = error_reg;
    assign load_count = count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are built from a word list, expected writes
// and final status come from the frame contents; a monitor checks every write pulse.
module tb_imem_loader;

    localparam int WIDTH = 32;
    localparam int ADD   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             cpu_rst;
    logic             done;
    logic             error;
    logic [ADD:0]     load_count;

    imem_loader #(.WIDTH(WIDTH), .ADD(ADD)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] payload[$];
    logic [7:0] junk[$];
    int         n_vec  = 0;
    int         n_miss = 0;
    bit         gaps   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (mem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             mem_addr, mem_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("write addr=0x%0h data=0x%08h", mem_addr, mem_wdata);
                    check("wr_addr", mem_addr, mon_e.addr);
                    check("wr_data", mem_wdata, mon_e.data);
                    check("rx_ready_stall", 32'(rx_ready), 32'd0);
                end
            end else begin
                check("rx_ready_idle", 32'(rx_ready), 32'd1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        acc = 1'b0;
        while (!acc) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 2) == 0) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end else begin
                rx_valid = 1'b1;
                rx_data  = b;
                acc      = rx_ready;
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"},   32'(rx_ready),   32'd1);
        check({tag, "_mem_we"},     32'(mem_we),     32'd0);
        check({tag, "_mem_addr"},   mem_addr,        32'd0);
        check({tag, "_mem_wdata"},  mem_wdata,       32'd0);
        check({tag, "_cpu_rst"},    32'(cpu_rst),    32'd1);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_error"},      32'(error),      32'd0);
        check({tag, "_load_count"}, 32'(load_count), 32'd0);
    endtask

    // Sends junk, then a frame of n words from payload (4n bytes), checksum optionally flipped.
    task automatic run_frame(input int n, input logic [7:0] chk_flip);
        logic [7:0]  chk_byte;
        logic [31:0] word;
        bit          legal;
        bit          ok;
        legal    = (n <= (1 << ADD));
        ok       = legal && (chk_flip == 8'h00);
        chk_byte = 8'h00;
        foreach (junk[i]) send_byte(junk[i]);
        send_byte(8'hA5);
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        if (legal) begin
            for (int w = 0; w < n; w++) begin
                word = {payload[4*w+3], payload[4*w+2], payload[4*w+1], payload[4*w]};
                exp_q.push_back('{addr: 32'(w * 4), data: word});
                for (int k = 0; k < 4; k++) begin
                    chk_byte = chk_byte ^ payload[4*w+k];
                    send_byte(payload[4*w+k]);
                end
            end
            send_byte(chk_byte ^ chk_flip);
        end
        go_idle();
        $display("frame n=%0d chk_flip=%0h gaps=%0d -> done=%0d error=%0d cpu_rst=%0d load_count=%0d",
                 n, chk_flip, gaps, done, error, cpu_rst, load_count);
        check("frame_done",    32'(done),    32'(ok));
        check("frame_error",   32'(error),   32'(!ok));
        check("frame_cpu_rst", 32'(cpu_rst), 32'(!ok));
        if (legal) check("frame_load_count", 32'(load_count), 32'(n));
        check("frame_pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic random_payload(input int n);
        payload.delete();
        for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom));
    endtask

    task automatic random_junk();
        logic [7:0] j;
        junk.delete();
        for (int i = 0; i < $urandom_range(0, 2); i++) begin
            j = 8'($urandom);
            if (j == 8'hA5) j = 8'h00;
            junk.push_back(j);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst      = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        check_reset_vals("post_reset");

        // Two-word program, good checksum 0x90.
        payload = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        junk.delete();
        run_frame(2, 8'h00);
        // Same program with checksum 0x91, then an empty frame.
        run_frame(2, 8'h01);
        payload.delete();
        run_frame(0, 8'h00);
        // Junk then oversized length 257.
        junk = '{8'h00, 8'hFF};
        run_frame(257, 8'h00);
        // Same two-word program through a stream with gaps.
        junk.delete();
        gaps    = 1'b1;
        payload = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_frame(2, 8'h00);
        gaps = 1'b0;

        // Reset after 6 data bytes of a 2-word frame: only the first word lands.
        random_payload(2);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        exp_q.push_back('{addr: 32'h0, data: {payload[3], payload[2], payload[1], payload[0]}});
        for (int i = 0; i < 6; i++) send_byte(payload[i]);
        go_idle();
        check("abort_pending_writes", 32'(exp_q.size()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("abort_reset");
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("abort_release");
        random_payload(2);
        run_frame(2, 8'h00);

        // Randomised frames.
        for (int f = 0; f < 20; f++) begin
            n    = $urandom_range(0, 6);
            gaps = 1'($urandom);
            random_payload(n);
            random_junk();
            run_frame(n, ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
        end

        // Full-capacity frame: last address is 0x3FC.
        gaps = 1'b0;
        junk.delete();
        random_payload(1 << ADD);
        run_frame(1 << ADD, 8'h00);
        n = $urandom_range(258, 1000);
        run_frame(n, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
